bt_stream_scheduler: RTL and testbench

- Round-robin scheduler that shares the single Bluetooth UART transmit path between NUM_SRC 16-bit data sources (sensor channels).
- Sits between the per-channel capture logic and the UART TX byte engine inside the FPGA Bluetooth connection top level.
- Each selected word goes out as a framed packet: header byte (HEADER_BASE + source id), data high byte, data low byte.
- Transmits only while the Bluetooth module reports connected (bt_state=1) and host mode enables streaming.

---
 rtl/bt_stream_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_bt_stream_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bt_stream_scheduler.sv
// bt_stream_scheduler
// Round-robin scheduler that shares one Bluetooth UART TX byte engine between
// NUM_SRC 16-bit sources. Each granted word is sent as a framed packet:
// header (HEADER_BASE + source id), data[15:8], data[7:0].
// Optional build macro: BT_SCHED_CHECKSUM_EN appends a 4th byte,
// header ^ data[15:8] ^ data[7:0].
//
// Ports:
//   clock, resetn   rising-edge clock, synchronous active-low reset
//   bt_state        Bluetooth link connected
//   stream_en       host streaming enable
//   src_valid       per-source word available
//   src_data        per-source word, source i at [16i+15:16i]
//   src_ack         one-cycle pulse, word captured (at most one bit high)
//   tx_byte         byte presented to UART TX, held until the next launch
//   tx_start        one-cycle launch pulse for tx_byte
//   tx_busy         UART TX busy
//   sched_state     FSM state code (IDLE=0 LOAD=1 SEND=2 WAIT_HI=3 WAIT_LO=4 NEXT=5)
//   packets_sent    completed packet count, wrapping
//   abort_flag      sticky: packet aborted by link loss
//
// All outputs are registered and reflect the state being entered, so src_ack
// is high during LOAD and tx_start/tx_byte are valid during SEND.

module bt_stream_scheduler #(
    parameter int unsigned NUM_SRC     = 4,
    parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   bt_state,
    input  logic                   stream_en,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [16*NUM_SRC-1:0]  src_data,
    output logic [NUM_SRC-1:0]     src_ack,
    output logic [7:0]             tx_byte,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [2:0]             sched_state,
    output logic [15:0]            packets_sent,
    output logic                   abort_flag
);

    localparam int unsigned IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
`ifdef BT_SCHED_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        NEXT    = 3'd5
    } schedState_t;

    schedState_t          state, stateNxt;
    logic [IDW-1:0]       rrPtr, rrPtrNxt;
    logic [1:0]           byteIdx, byteIdxNxt;
    logic [15:0]          wordLatch, wordLatchNxt;
    logic [IDW-1:0]       idLatch, idLatchNxt;
    logic [NUM_SRC-1:0]   srcAckNxt;
    logic [7:0]           txByteNxt;
    logic                 txStartNxt;
    logic [15:0]          packetsNxt;
    logic                 abortNxt;

    logic                 grantFound;
    logic [IDW-1:0]       grantId;

    // First valid source at or above rrPtr, wrapping modulo NUM_SRC.
    function automatic logic [IDW:0] pickGrant(input logic [NUM_SRC-1:0] valid,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW:0] res;
        int unsigned  cand;
        res = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = (32'(ptr) + k) % NUM_SRC;
            if (!res[IDW] && valid[cand]) begin
                res = {1'b1, IDW'(cand)};
            end
        end
        return res;
    endfunction

    // Packet byte for a given position within the frame.
    function automatic logic [7:0] frameByte(input logic [1:0]     idx,
                                             input logic [IDW-1:0] id,
                                             input logic [15:0]    word);
        logic [7:0] header;
        header = HEADER_BASE + 8'(id);
        case (idx)
            2'd0:    return header;
            2'd1:    return word[15:8];
            2'd2:    return word[7:0];
`ifdef BT_SCHED_CHECKSUM_EN
            default: return header ^ word[15:8] ^ word[7:0];
`else
            default: return 8'h00;
`endif
        endcase
    endfunction

    always_comb begin
        {grantFound, grantId} = pickGrant(src_valid, rrPtr);
    end

    // Next-state and next-output decode.
    always_comb begin
        stateNxt     = state;
        rrPtrNxt     = rrPtr;
        byteIdxNxt   = byteIdx;
        wordLatchNxt = wordLatch;
        idLatchNxt   = idLatch;
        srcAckNxt    = '0;
        txByteNxt    = tx_byte;
        txStartNxt   = 1'b0;
        packetsNxt   = packets_sent;
        abortNxt     = abort_flag;

        case (state)
            IDLE: begin
                if (bt_state && stream_en && grantFound) begin
                    stateNxt     = LOAD;
                    idLatchNxt   = grantId;
                    wordLatchNxt = src_data[{grantId, 4'b0000} +: 16];
                    srcAckNxt    = NUM_SRC'(1) << grantId;
                    rrPtrNxt     = (32'(grantId) == NUM_SRC - 1) ? '0 : grantId + IDW'(1);
                    byteIdxNxt   = 2'd0;
                end
            end
            LOAD: begin
                stateNxt   = SEND;
                txStartNxt = 1'b1;
                txByteNxt  = frameByte(byteIdx, idLatch, wordLatch);
            end
            SEND: begin
                stateNxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    stateNxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    stateNxt = NEXT;
                end
            end
            NEXT: begin
                // The byte on the wire has completed; link loss is only acted on here.
                if (!bt_state || !stream_en) begin
                    stateNxt = IDLE;
                    if (!bt_state) begin
                        abortNxt = 1'b1;
                    end
                end else if (byteIdx == LAST_IDX) begin
                    stateNxt   = IDLE;
                    packetsNxt = packets_sent + 16'd1;
                end else begin
                    stateNxt   = SEND;
                    byteIdxNxt = byteIdx + 2'd1;
                    txStartNxt = 1'b1;
                    txByteNxt  = frameByte(byteIdx + 2'd1, idLatch, wordLatch);
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        if (!stream_en) begin
            abortNxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            rrPtr        <= '0;
            byteIdx      <= 2'd0;
            wordLatch    <= 16'd0;
            idLatch      <= '0;
            src_ack      <= '0;
            tx_byte      <= 8'd0;
            tx_start     <= 1'b0;
            packets_sent <= 16'd0;
            abort_flag   <= 1'b0;
        end else begin
            state        <= stateNxt;
            rrPtr        <= rrPtrNxt;
            byteIdx      <= byteIdxNxt;
            wordLatch    <= wordLatchNxt;
            idLatch      <= idLatchNxt;
            src_ack      <= srcAckNxt;
            tx_byte      <= txByteNxt;
            tx_start     <= txStartNxt;
            packets_sent <= packetsNxt;
            abort_flag   <= abortNxt;
        end
    end

    assign sched_state = 3'(state);

endmodule

// File: tb/tb_bt_stream_scheduler.sv
// Directed bench for bt_stream_scheduler with a simple UART busy model.

module tb_bt_stream_scheduler;

    localparam int unsigned NS = 4;
`ifdef BT_SCHED_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            bt_state = 1'b0;
    logic            stream_en = 1'b0;
    logic [NS-1:0]   src_valid = '0;
    logic [16*NS-1:0] src_data = '0;
    logic [NS-1:0]   src_ack;
    logic [7:0]      tx_byte;
    logic            tx_start;
    logic            tx_busy = 1'b0;
    logic [2:0]      sched_state;
    logic [15:0]     packets_sent;
    logic            abort_flag;

    int nCmp = 0;
    int nErr = 0;

    bt_stream_scheduler #(.NUM_SRC(NS), .HEADER_BASE(8'hA0)) dut (
        .clock(clock), .resetn(resetn), .bt_state(bt_state), .stream_en(stream_en),
        .src_valid(src_valid), .src_data(src_data), .src_ack(src_ack),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .sched_state(sched_state), .packets_sent(packets_sent), .abort_flag(abort_flag)
    );

    always #5 clock = ~clock;

    // UART model: busy rises the cycle after tx_start and stays high 10 cycles.
    int busyCnt = 0;
    always @(posedge clock) begin
        if (tx_start) begin
            tx_busy <= 1'b1;
            busyCnt <= 10;
        end else if (busyCnt > 1) begin
            busyCnt <= busyCnt - 1;
        end else if (busyCnt == 1) begin
            busyCnt <= 0;
            tx_busy <= 1'b0;
        end
    end

    // Monitor: log launched bytes, count acks/starts, note protocol violations.
    logic [7:0] txLog[$];
    int ackCnt[NS];
    int startCnt = 0;
    int protoErr = 0;
    initial for (int i = 0; i < NS; i++) ackCnt[i] = 0;
    always @(posedge clock) begin
        if (tx_start) begin
            txLog.push_back(tx_byte);
            startCnt++;
            if (tx_busy) protoErr++;
        end
        if ($countones(src_ack) > 1) protoErr++;
        for (int i = 0; i < NS; i++) if (src_ack[i]) ackCnt[i]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp)
        else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int logBase, startBase, n;
    int ackBase[NS];
    logic [7:0] ck;

    initial begin
        // Reset
        repeat (2) @(negedge clock);
        check("rst_state", 32'(sched_state), 32'd0);
        check("rst_ack", 32'(src_ack), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_byte", 32'(tx_byte), 32'd0);
        check("rst_pkts", 32'(packets_sent), 32'd0);
        check("rst_abort", 32'(abort_flag), 32'd0);
        resetn = 1'b1;

        // Idle gating: link down blocks scheduling
        bt_state = 1'b0; stream_en = 1'b1; src_valid = 4'b0001;
        for (int i = 0; i < NS; i++) ackBase[i] = ackCnt[i];
        startBase = startCnt;
        repeat (50) @(negedge clock);
        check("gate_state", 32'(sched_state), 32'd0);
        check("gate_ack", 32'(ackCnt[0] - ackBase[0]), 32'd0);
        check("gate_start", 32'(startCnt - startBase), 32'd0);
        src_valid = '0;

        // Single packet from source 2
        src_data[32 +: 16] = 16'h1234;
        logBase = txLog.size();
        ackBase[2] = ackCnt[2];
        bt_state = 1'b1; src_valid = 4'b0100;
        @(negedge clock);
        check("single_load_state", 32'(sched_state), 32'd1);
        check("single_ack", 32'(src_ack), 32'h4);
        src_valid = '0;
        @(negedge clock);
        check("single_send_state", 32'(sched_state), 32'd2);
        check("single_start", 32'(tx_start), 32'd1);
        check("single_hdr_now", 32'(tx_byte), 32'hA2);
        n = 0;
        while (packets_sent != 16'd1 && n < 300) begin @(negedge clock); n++; end
        check("single_done", 32'(packets_sent), 32'd1);
        check("single_idle", 32'(sched_state), 32'd0);
        check("single_nbytes", 32'(txLog.size() - logBase), 32'(NB));
        check("single_b0", 32'(txLog[logBase]), 32'hA2);
        check("single_b1", 32'(txLog[logBase + 1]), 32'h12);
        check("single_b2", 32'(txLog[logBase + 2]), 32'h34);
`ifdef BT_SCHED_CHECKSUM_EN
        check("single_b3", 32'(txLog[logBase + 3]), 32'h84);
`endif
        check("single_ack_cnt", 32'(ackCnt[2] - ackBase[2]), 32'd1);

        // Link loss during the data-high byte of a source 3 packet
        src_data[48 +: 16] = 16'hBEEF;
        logBase = txLog.size();
        src_valid = 4'b1000;
        @(negedge clock);
        src_valid = '0;
        n = 0;
        while (txLog.size() < logBase + 2 && n < 200) begin @(negedge clock); n++; end
        check("loss_reach_hi", 32'(txLog.size() - logBase), 32'd2);
        bt_state = 1'b0;
        n = 0;
        while (sched_state != 3'd0 && n < 200) begin @(negedge clock); n++; end
        check("loss_idle", 32'(sched_state), 32'd0);
        repeat (20) @(negedge clock);
        check("loss_nbytes", 32'(txLog.size() - logBase), 32'd2);
        check("loss_hdr", 32'(txLog[logBase]), 32'hA3);
        check("loss_hi", 32'(txLog[logBase + 1]), 32'hBE);
        check("loss_hold", 32'(tx_byte), 32'hBE);
        check("loss_abort", 32'(abort_flag), 32'd1);
        check("loss_pkts", 32'(packets_sent), 32'd1);
        stream_en = 1'b0;
        @(negedge clock);
        check("abort_clear", 32'(abort_flag), 32'd0);
        stream_en = 1'b1; bt_state = 1'b1;

        // Reset during WAIT_LO of a source 1 packet
        src_data[16 +: 16] = 16'h5A5A;
        src_valid = 4'b0010;
        @(negedge clock);
        src_valid = '0;
        n = 0;
        while (sched_state != 3'd4 && n < 200) begin @(negedge clock); n++; end
        check("rst_mid_reach", 32'(sched_state), 32'd4);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("rst_mid_state", 32'(sched_state), 32'd0);
        check("rst_mid_ack", 32'(src_ack), 32'd0);
        check("rst_mid_start", 32'(tx_start), 32'd0);
        check("rst_mid_byte", 32'(tx_byte), 32'd0);
        check("rst_mid_pkts", 32'(packets_sent), 32'd0);
        check("rst_mid_abort", 32'(abort_flag), 32'd0);
        n = 0;
        while (tx_busy && n < 50) begin @(negedge clock); n++; end

        // Round robin with all sources valid; rotation must restart at source 0
        src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        logBase = txLog.size();
        for (int i = 0; i < NS; i++) ackBase[i] = ackCnt[i];
        src_valid = 4'b1111;
        n = 0;
        while (packets_sent != 16'd5 && n < 2000) begin @(negedge clock); n++; end
        src_valid = '0;
        check("rr_done", 32'(packets_sent), 32'd5);
        check("rr_h0", 32'(txLog[logBase + 0 * NB]), 32'hA0);
        check("rr_h1", 32'(txLog[logBase + 1 * NB]), 32'hA1);
        check("rr_h2", 32'(txLog[logBase + 2 * NB]), 32'hA2);
        check("rr_h3", 32'(txLog[logBase + 3 * NB]), 32'hA3);
        check("rr_h4", 32'(txLog[logBase + 4 * NB]), 32'hA0);
        check("rr_d1", 32'(txLog[logBase + NB + 1]), 32'h22);
        check("rr_d3", 32'(txLog[logBase + 3 * NB + 2]), 32'h44);
        check("rr_ack0", 32'(ackCnt[0] - ackBase[0]), 32'd2);
        check("rr_ack1", 32'(ackCnt[1] - ackBase[1]), 32'd1);
        check("rr_ack2", 32'(ackCnt[2] - ackBase[2]), 32'd1);
        check("rr_ack3", 32'(ackCnt[3] - ackBase[3]), 32'd1);
        repeat (5) @(negedge clock);
        check("rr_idle", 32'(sched_state), 32'd0);

        // Counter wrap: preload 16'hFFFF and complete one more packet
        force dut.packets_sent = 16'hFFFF;
        @(negedge clock);
        release dut.packets_sent;
        @(negedge clock);
        check("wrap_preload", 32'(packets_sent), 32'hFFFF);
        logBase = txLog.size();
        src_data[0 +: 16] = 16'hC3A5;
        src_valid = 4'b0001;
        @(negedge clock);
        src_valid = '0;
        n = 0;
        while (packets_sent != 16'd0 && n < 300) begin @(negedge clock); n++; end
        check("wrap_zero", 32'(packets_sent), 32'd0);
        check("wrap_nbytes", 32'(txLog.size() - logBase), 32'(NB));
        ck = 8'hA0 ^ 8'hC3 ^ 8'hA5;
`ifdef BT_SCHED_CHECKSUM_EN
        check("wrap_ck", 32'(txLog[logBase + 3]), 32'(ck));
`endif
        check("wrap_lo", 32'(txLog[logBase + 2]), 32'hA5);

        check("protocol", 32'(protoErr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
